// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - one-entry output register with a full_n-style push handshake
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             full_n,
  output logic             free,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  // The slot can take a new word when it is empty or its word leaves this cycle.
  assign free = ~valid | full_n;

  // Hold the word until the downstream FIFO accepts it; a load wins over a drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (full_n) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_stream_packer.sv
// rtl/fifo_stream_packer.sv - packs RATIO narrow FIFO words into one wide word, flushing on EOT
module fifo_stream_packer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4,
  parameter int CNT_W    = $clog2(RATIO + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_empty_n,
  output logic                              in_read,
  input  logic [IN_WIDTH:0]                 in_dout,
  input  logic                              out_full_n,
  output logic                              out_write,
  output logic [CNT_W+RATIO*IN_WIDTH:0]     out_din
);

  localparam int LANES_W = RATIO * IN_WIDTH;
  localparam int OUT_W   = 1 + CNT_W + LANES_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RATIO);

  logic [LANES_W-1:0]  acc;
  logic [CNT_W-1:0]    cnt;
  logic [LANES_W-1:0]  full_lanes;
  logic [OUT_W-1:0]    load_word;
  logic [IN_WIDTH-1:0] payload;
  logic                head_eot;
  logic                cnt_zero;
  logic                is_last;
  logic                free;
  logic                flush;
  logic                load;

  assign head_eot = in_dout[IN_WIDTH];
  assign payload  = in_dout[IN_WIDTH-1:0];
  assign cnt_zero = (cnt == '0);
  assign is_last  = (cnt == LAST_CNT);

  // Non-completing data words always pop; anything that produces an output word needs a free slot.
  // An EOT only pops once the partial word ahead of it has been flushed.
  assign in_read = reset & in_empty_n & (head_eot ? (free & cnt_zero) : (~is_last | free));
  assign flush   = reset & in_empty_n & head_eot & ~cnt_zero & free;
  assign load    = flush | (in_read & (head_eot | is_last));

  // Build the word handed to the output register: full word, flushed partial, or EOT token.
  always_comb begin
    full_lanes = acc;
    full_lanes[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = payload;
    load_word = {1'b0, FULL_CNT, full_lanes};
    if (head_eot) begin
      if (flush) begin
        load_word = {1'b0, cnt, acc};
      end else begin
        load_word = {1'b1, {CNT_W{1'b0}}, {LANES_W{1'b0}}};
      end
    end
  end

  // Fill lanes in arrival order; clear the accumulator whenever its contents move to the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_read && !head_eot) begin
      for (int i = 0; i < RATIO; i++) begin
        if (cnt == CNT_W'(i)) begin
          acc[i*IN_WIDTH +: IN_WIDTH] <= payload;
        end
      end
      cnt <= cnt + 1'b1;
    end
  end

  stream_out_reg #(
    .WIDTH (OUT_W)
  ) u_out_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .din    (load_word),
    .full_n (out_full_n),
    .free   (free),
    .valid  (out_write),
    .dout   (out_din)
  );

endmodule

// File: tb/tb_fifo_stream_packer.sv
// tb/tb_fifo_stream_packer.sv - directed and randomised bench for fifo_stream_packer
module tb_fifo_stream_packer;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int CW = 3;
  localparam int OW = 1 + CW + R * IW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_empty_n;
  logic          in_read;
  logic [IW:0]   in_dout;
  logic          out_full_n;
  logic          out_write;
  logic [OW-1:0] out_din;

  always #5 clk = ~clk;

  fifo_stream_packer #(
    .IN_WIDTH (IW),
    .RATIO    (R),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_empty_n (in_empty_n),
    .in_read    (in_read),
    .in_dout    (in_dout),
    .out_full_n (out_full_n),
    .out_write  (out_write),
    .out_din    (out_din)
  );

  int checks = 0;
  int errors = 0;

  logic [IW:0]   src_q[$];
  logic [OW-1:0] out_q[$];
  int            out_cyc[$];
  logic [OW-1:0] exp_q[$];

  bit            src_en = 1'b1;
  bit            dst_rdy = 1'b1;
  int            cyc = 0;
  int            pops = 0;
  int            eot_stalls = 0;
  int            din_changes = 0;
  logic [OW-1:0] held;
  bit            held_v = 1'b0;

  logic [31:0]   m_acc = '0;
  int            m_n = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] wd(input bit e, input int n, input logic [31:0] dt);
    logic [CW-1:0] c;
    c = n[CW-1:0];
    return {e, c, dt};
  endfunction

  function automatic logic [OW-1:0] got(input int i);
    if (out_q.size() > i) return out_q[i];
    return {OW{1'bx}};
  endfunction

  task automatic drive();
    in_empty_n = src_en && (src_q.size() > 0);
    in_dout    = (src_q.size() > 0) ? src_q[0] : '0;
    out_full_n = dst_rdy;
  endtask

  task automatic cycle();
    bit            p;
    bit            q;
    logic [OW-1:0] d;
    drive();
    @(negedge clk);
    p = in_read & in_empty_n;
    q = out_write & out_full_n;
    d = out_din;
    if (in_empty_n && in_dout[IW] && !in_read && out_full_n) eot_stalls++;
    if (out_write && !out_full_n) begin
      if (held_v && d !== held) din_changes++;
      held   = d;
      held_v = 1'b1;
    end else begin
      held_v = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (p) begin
      void'(src_q.pop_front());
      pops++;
    end
    if (q) begin
      out_q.push_back(d);
      out_cyc.push_back(cyc);
    end
    drive();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, out_q.size(), n);
  endtask

  task automatic start_scn();
    out_q.delete();
    out_cyc.delete();
    pops = 0;
    eot_stalls = 0;
    din_changes = 0;
  endtask

  task automatic model_word(input logic [IW:0] w);
    if (w[IW]) begin
      if (m_n > 0) exp_q.push_back(wd(1'b0, m_n, m_acc));
      exp_q.push_back(wd(1'b1, 0, 32'h0));
      m_acc = '0;
      m_n = 0;
    end else begin
      m_acc[m_n*IW +: IW] = w[IW-1:0];
      m_n++;
      if (m_n == R) begin
        exp_q.push_back(wd(1'b0, R, m_acc));
        m_acc = '0;
        m_n = 0;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_read", in_read, 0);
    check("rst_out_write", out_write, 0);
    check("rst_out_din", out_din, 0);
    reset = 1'b1;
    #1;

    // Streaming, eight words with an always-ready sink
    start_scn();
    for (int i = 1; i <= 8; i++) src_q.push_back(9'(i));
    run_until("stream_count", 2, 40);
    check("stream_w0", got(0), wd(1'b0, 4, 32'h04030201));
    check("stream_w1", got(1), wd(1'b0, 4, 32'h08070605));
    check("stream_gap", (out_cyc.size() > 1) ? out_cyc[1] - out_cyc[0] : -1, 4);
    repeat (4) cycle();

    // Partial word followed by EOT
    start_scn();
    src_q.push_back(9'h0A1);
    src_q.push_back(9'h0A2);
    src_q.push_back(9'h155);
    run_until("part_count", 2, 30);
    check("part_w0", got(0), wd(1'b0, 2, 32'h0000A2A1));
    check("part_w1", got(1), wd(1'b1, 0, 32'h0));
    check("part_gap", (out_cyc.size() > 1) ? out_cyc[1] - out_cyc[0] : -1, 1);
    check("part_flush_stall", eot_stalls, 1);
    repeat (4) cycle();
    check("part_total", out_q.size(), 2);

    // EOT landing on a word boundary
    start_scn();
    src_q.push_back(9'h0B1);
    src_q.push_back(9'h0B2);
    src_q.push_back(9'h0B3);
    src_q.push_back(9'h0B4);
    src_q.push_back(9'h100);
    run_until("align_count", 2, 30);
    check("align_w0", got(0), wd(1'b0, 4, 32'hB4B3B2B1));
    check("align_w1", got(1), wd(1'b1, 0, 32'h0));
    check("align_no_flush", eot_stalls, 0);
    repeat (4) cycle();
    check("align_total", out_q.size(), 2);

    // Backpressure for ten cycles with eight words queued
    start_scn();
    dst_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) src_q.push_back(9'(8'hC0 + i));
    repeat (10) cycle();
    check("bp_pops", pops, 7);
    check("bp_out_write", out_write, 1);
    check("bp_out_din", out_din, wd(1'b0, 4, 32'hC4C3C2C1));
    check("bp_din_stable", din_changes, 0);
    dst_rdy = 1'b1;
    run_until("bp_count", 2, 30);
    check("bp_w0", got(0), wd(1'b0, 4, 32'hC4C3C2C1));
    check("bp_w1", got(1), wd(1'b0, 4, 32'hC8C7C6C5));
    check("bp_src_drained", src_q.size(), 0);
    repeat (4) cycle();

    // Reset in the middle of a word
    start_scn();
    src_q.push_back(9'h0D1);
    src_q.push_back(9'h0D2);
    repeat (2) cycle();
    check("mid_pops", pops, 2);
    src_q.push_back(9'h0D3);
    drive();
    reset = 1'b0;
    #1;
    check("mid_rst_out_write", out_write, 0);
    check("mid_rst_in_read", in_read, 0);
    check("mid_rst_out_din", out_din, 0);
    repeat (2) cycle();
    check("mid_rst_no_pop", pops, 2);
    src_q.delete();
    drive();
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) src_q.push_back(9'(8'hE0 + i));
    run_until("mid_count", 1, 30);
    check("mid_w0", got(0), wd(1'b0, 4, 32'hE4E3E2E1));
    repeat (4) cycle();
    check("mid_total", out_q.size(), 1);

    // Randomised stress against the reference model
    start_scn();
    exp_q.delete();
    m_acc = '0;
    m_n = 0;
    for (int i = 0; i < 80; i++) begin
      logic [IW:0] w;
      w = {($urandom_range(5) == 0) ? 1'b1 : 1'b0, 8'($urandom_range(255))};
      src_q.push_back(w);
      model_word(w);
    end
    src_q.push_back(9'h1FF);
    model_word(9'h1FF);
    begin
      int k = 0;
      while (out_q.size() < exp_q.size() && k < 3000) begin
        src_en  = ($urandom_range(3) != 0);
        dst_rdy = ($urandom_range(2) != 0);
        cycle();
        k++;
      end
    end
    src_en = 1'b1;
    dst_rdy = 1'b1;
    repeat (4) cycle();
    check("rnd_count", out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check("rnd_word", got(i), exp_q[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
